// File: rtl/png_packet_serializer.sv
// Packet-to-byte serializer feeding the hard_png decoder: buffers DEPTH wide packets and streams them MSB-first.
// Optional statistics counters are enabled by defining PNG_SER_STATS_EN.
module png_packet_serializer #(
   parameter int PKT_W = 552,
   parameter int DEPTH = 2,
   parameter int LEN_W = $clog2(PKT_W/8+1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PKT_W-1:0] in_data,
   input  logic [LEN_W-1:0] in_len,
   input  logic             in_last,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_byte,
   output logic             out_last
`ifdef PNG_SER_STATS_EN
   ,
   output logic [31:0]      stat_pkts,
   output logic [31:0]      stat_bytes
`endif
);

   localparam int NB    = PKT_W/8;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_STREAM = 1'b1;

   logic [PKT_W-1:0] slot_data [DEPTH];
   logic [LEN_W-1:0] slot_len  [DEPTH];
   logic             slot_last [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic [0:0]       state;
   logic [IDX_W-1:0] idx;

   logic [LEN_W-1:0] len_clamped;
   logic [PKT_W-1:0] head_data;
   logic [LEN_W-1:0] head_len;
   logic             head_last;
   logic [7:0]       head_bytes [NB];
   logic             streaming;
   logic             last_byte;
   logic             handshake;
   logic             push;
   logic             pop;

   assign len_clamped = (in_len > LEN_W'(NB)) ? LEN_W'(NB) : in_len;

   assign head_data = slot_data[rd_ptr];
   assign head_len  = slot_len[rd_ptr];
   assign head_last = slot_last[rd_ptr];

   // Byte 0 sits in the top byte lane of the packet.
   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_byte_lane
         assign head_bytes[gi] = head_data[PKT_W-1-8*gi -: 8];
      end
   endgenerate

   assign streaming = (state == ST_STREAM);
   assign out_valid = streaming && (head_len != '0);
   assign last_byte = (LEN_W'(idx) == head_len - LEN_W'(1));
   assign out_byte  = out_valid ? head_bytes[idx] : 8'h00;
   assign out_last  = out_valid && head_last && last_byte;

   assign handshake = out_valid && out_ready;
   assign push      = in_valid && in_ready && !flush;
   // A zero-length head carries no bytes, so it is retired without a handshake.
   assign pop       = streaming && ((head_len == '0) || (handshake && last_byte));

   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + CNT_W'(1);
      end else if (pop && !push) begin
         count_next = count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         slot_data[wr_ptr] <= in_data;
         slot_len[wr_ptr]  <= len_clamped;
         slot_last[wr_ptr] <= in_last;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         state    <= ST_IDLE;
         idx      <= '0;
         in_ready <= 1'b0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         state    <= ST_IDLE;
         idx      <= '0;
         in_ready <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count    <= count_next;
         // Registered from the post-update occupancy so it never follows out_ready combinationally.
         in_ready <= (count_next < CNT_W'(DEPTH));
         case (state)
            ST_IDLE: begin
               idx <= '0;
               if (count != '0) begin
                  state <= ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (pop) begin
                  idx   <= '0;
                  state <= (count_next != '0) ? ST_STREAM : ST_IDLE;
               end else if (handshake) begin
                  idx <= idx + IDX_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               idx   <= '0;
            end
         endcase
      end
   end

`ifdef PNG_SER_STATS_EN
   // Statistics survive flush; a handshake that coincides with flush is discarded and not counted.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stat_pkts  <= '0;
         stat_bytes <= '0;
      end else begin
         if (push) begin
            stat_pkts <= stat_pkts + 32'd1;
         end
         if (handshake && !flush) begin
            stat_bytes <= stat_bytes + 32'd1;
         end
      end
   end
`endif

endmodule
